// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: hold/flush arbitration, redirect and wrong-path
// squash FSM for the 5-stage core, plus stall/redirect counters.
module pipe_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        id_rs1_addr_i,
   input  logic [4:0]        id_rs2_addr_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic [4:0]        ex_rd_addr_i,
   input  logic              ex_is_load_i,
   input  logic              ex_jump_en_i,
   input  logic [ADDR_W-1:0] ex_jump_addr_i,
   input  logic              ex_busy_i,
   input  logic              mem_stall_i,
   output logic              pc_hold_o,
   output logic              if_id_hold_o,
   output logic              if_id_flush_o,
   output logic              id_ex_hold_o,
   output logic              id_ex_flush_o,
   output logic              pc_jump_en_o,
   output logic [ADDR_W-1:0] pc_jump_addr_o,
   output logic [1:0]        state_o,
   output logic [CNT_W-1:0]  stall_cnt_o,
   output logic [CNT_W-1:0]  redir_cnt_o
);

   localparam int FW = $clog2(FLUSH_CYCLES) + 1;
   localparam bit MULTI = (FLUSH_CYCLES > 1);
   localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYCLES - 1);
   localparam logic [FW-1:0] FONE = FW'(1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      BUSY  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t state, state_nx;
   logic [FW-1:0] fcnt, fcnt_nx;
   logic [CNT_W-1:0] stall_cnt, redir_cnt;

   logic rs1_hit, rs2_hit, lu;
   logic sel_stall, sel_busy, sel_jump, sel_lu;

   assign rs1_hit = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
   assign rs2_hit = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
   assign lu = ex_is_load_i && (ex_rd_addr_i != 5'd0)
             && (rs1_hit || rs2_hit);

   // One-hot priority selects so the decode below can be a unique case.
   assign sel_stall = mem_stall_i;
   assign sel_busy  = !mem_stall_i && ex_busy_i;
   assign sel_jump  = !mem_stall_i && !ex_busy_i && ex_jump_en_i;
   assign sel_lu    = !mem_stall_i && !ex_busy_i
                    && !ex_jump_en_i && lu;

   always_comb begin
      pc_hold_o      = 1'b0;
      if_id_hold_o   = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_hold_o   = 1'b0;
      id_ex_flush_o  = 1'b0;
      pc_jump_en_o   = 1'b0;
      pc_jump_addr_o = '0;
      state_nx       = state;
      fcnt_nx        = fcnt;

      unique case (state)
         RUN, BUSY: begin
            unique case (1'b1)
               sel_stall: begin
                  pc_hold_o    = 1'b1;
                  if_id_hold_o = 1'b1;
                  id_ex_hold_o = 1'b1;
               end
               sel_busy: begin
                  pc_hold_o    = 1'b1;
                  if_id_hold_o = 1'b1;
                  id_ex_hold_o = 1'b1;
                  state_nx     = BUSY;
               end
               sel_jump: begin
                  pc_jump_en_o   = 1'b1;
                  pc_jump_addr_o = ex_jump_addr_i;
                  if_id_flush_o  = 1'b1;
                  id_ex_flush_o  = 1'b1;
                  if (MULTI) begin
                     state_nx = FLUSH;
                     fcnt_nx  = FLOAD;
                  end else begin
                     state_nx = RUN;
                  end
               end
               sel_lu: begin
                  pc_hold_o     = 1'b1;
                  if_id_hold_o  = 1'b1;
                  id_ex_flush_o = 1'b1;
                  state_nx      = RUN;
               end
               default: state_nx = RUN;
            endcase
         end
         FLUSH: begin
            if (mem_stall_i) begin
               pc_hold_o    = 1'b1;
               if_id_hold_o = 1'b1;
               id_ex_hold_o = 1'b1;
            end else begin
               if_id_flush_o = 1'b1;
               id_ex_flush_o = 1'b1;
               if (fcnt <= FONE) begin
                  state_nx = RUN;
                  fcnt_nx  = '0;
               end else begin
                  fcnt_nx = fcnt - FONE;
               end
            end
         end
         default: begin
            state_nx = RUN;
            fcnt_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         fcnt      <= '0;
         stall_cnt <= '0;
         redir_cnt <= '0;
      end else begin
         state     <= state_nx;
         fcnt      <= fcnt_nx;
         stall_cnt <= stall_cnt + CNT_W'(pc_hold_o);
         redir_cnt <= redir_cnt + CNT_W'(pc_jump_en_o);
      end
   end

   assign state_o     = state;
   assign stall_cnt_o = stall_cnt;
   assign redir_cnt_o = redir_cnt;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV core. Drives hold and flush for PC, if_id and id_ex, and drives the PC redirect.
- Arbitrates four events in fixed priority: bus stall, multi-cycle EX busy, EX-resolved jump, and load-use hazard against the operands being decoded in ID.
- Runs a small FSM that keeps squashing wrong-path fetches for a configurable number of cycles after a redirect.
- Keeps stall and redirect performance counters.

Parameters:
- ADDR_W, 32, PC/jump address width.
- FLUSH_CYCLES, 2, total cycles if_id is flushed per redirect (≥1; 1 means the redirect cycle only).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1_addr_i  in  5  rs1 index being decoded.
- id_rs2_addr_i  in  5  rs2 index being decoded.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- ex_rd_addr_i  in  5  destination of instruction in EX.
- ex_is_load_i  in  1  instruction in EX is a load.
- ex_jump_en_i  in  1  EX resolved a taken branch/jal/jalr.
- ex_jump_addr_i  in  ADDR_W  target (base+offset) from EX.
- ex_busy_i  in  1  multi-cycle EX op not complete.
- mem_stall_i  in  1  instruction/data bus not ready.
- pc_hold_o  out  1  freeze PC.
- if_id_hold_o  out  1  freeze if_id register.
- if_id_flush_o  out  1  load NOP into if_id.
- id_ex_hold_o  out  1  freeze id_ex register.
- id_ex_flush_o  out  1  load NOP (reg_wen=0, rd=0) into id_ex.
- pc_jump_en_o  out  1  load PC with pc_jump_addr_o.
- pc_jump_addr_o  out  ADDR_W  redirect target.
- state_o  out  2  FSM state: 0 RUN, 1 BUSY, 2 FLUSH.
- stall_cnt_o  out  CNT_W  cycles with pc_hold_o=1.
- redir_cnt_o  out  CNT_W  accepted redirects.

Behaviour:
- Registered: state, flush down-counter fcnt (width clog2(FLUSH_CYCLES)+1), both perf counters. All other outputs are combinational from state and inputs (Mealy), so a redirect takes effect in the same cycle EX resolves it.
- Reset, async on rst_n=0: state=RUN, fcnt=0, counters=0. Outputs are then all 0 except whatever the combinational RUN decode yields; pc_jump_addr_o=0 unless pc_jump_en_o=1.
- Asserting reset mid-FLUSH or mid-BUSY aborts immediately to RUN.
- Load-use hazard, lu = ex_is_load_i & (ex_rd_addr_i!=0) & ((id_rs1_used_i & id_rs1_addr_i==ex_rd_addr_i) | (id_rs2_used_i & id_rs2_addr_i==ex_rd_addr_i)).
- RUN, first match wins:
  1. mem_stall_i: pc_hold, if_id_hold and id_ex_hold =1; no flush; jump ignored (EX re-presents it). Stay RUN.
  2. ex_busy_i: same three holds; go BUSY.
  3. ex_jump_en_i: pc_jump_en_o=1, pc_jump_addr_o=ex_jump_addr_i, if_id_flush=1, id_ex_flush=1; redir_cnt+1. If FLUSH_CYCLES>1: fcnt=FLUSH_CYCLES-1 and go FLUSH; else stay RUN.
  4. lu: pc_hold=1, if_id_hold=1, id_ex_flush=1 (one bubble). Stay RUN; the hazard clears the next cycle because the load moves to MEM.
  5. Otherwise all control outputs 0.
- BUSY:
  - While ex_busy_i=1 or mem_stall_i=1, hold as in RUN items 1/2.
  - When both are 0, evaluate RUN items 3-5 in that same cycle and go RUN, or go FLUSH if item 3 fires.
- FLUSH:
  - if_id_flush=1, id_ex_flush=1, no holds.
  - fcnt decrements; at fcnt==1 return to RUN.
  - mem_stall_i=1 freezes fcnt and asserts the three holds instead of the flushes.
  - ex_jump_en_i and lu are ignored, because EX holds a bubble by construction; a bench assertion checks ex_jump_en_i=0 here.
- Hold and flush are never both asserted on the same register.
- stall_cnt increments every cycle pc_hold_o=1 (this includes lu cycles). Both counters wrap modulo 2^CNT_W.

Test Plan:
- Back-to-back ALU ops, no hazards → all control outputs 0, state_o=0 throughout, stall_cnt_o=0.
- ex_is_load_i=1, ex_rd=5, id rs2=5 used → one cycle with pc_hold=1, if_id_hold=1, id_ex_flush=1, then clear; stall_cnt_o=1. Same stimulus with ex_rd=0 → no stall.
- ex_jump_en_i=1, addr=0x80000040, FLUSH_CYCLES=2 → pc_jump_en_o=1 with 0x80000040 that cycle; if_id_flush=1 for exactly 2 cycles; state 0→2→0; redir_cnt_o=1.
- ex_busy_i high 5 cycles, jump asserted on the release cycle → 5 hold cycles in BUSY, then redirect in the same cycle busy falls, state 1→2; stall_cnt_o=5.
- mem_stall_i=1 for 3 cycles during FLUSH with fcnt=1 → fcnt frozen, holds asserted and no flush for those 3 cycles; one further flush cycle after release, then RUN.
- rst_n pulsed low mid-FLUSH and mid-BUSY → state_o=0 and counters 0 asynchronously, before the next clk edge.
